// File: rtl/otter_fetch_buffer.sv
// otter_fetch_buffer: owns the fetch PC, issues word reads on memory port 1 and queues PC-tagged words for decode.
// Latency: issue in N -> IR_VALID in N+2; a redirect or reset in R gives the first new IR_VALID at R+3.
// Backpressure: IR_READY low fills the queue; MEM_READ1 stays low while buffered + in-flight equals DEPTH.
// Optional: OTTER_FETCH_ERR_EN tags each word fetched beyond the 2**ACTUAL_WIDTH-word memory with IR_ERR.
module otter_fetch_buffer #(
   parameter logic [31:0] RESET_PC     = 32'h00000000,
   parameter int          DEPTH        = 4,
   parameter int          ACTUAL_WIDTH = 14
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic [31:0] MEM_ADDR1,
   output logic        MEM_READ1,
   input  logic [31:0] MEM_DOUT1,
   output logic        IR_VALID,
   output logic [31:0] IR,
   output logic [31:0] IR_PC,
   input  logic        IR_READY,
   output logic        IR_ERR
);
   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACTUAL_WIDTH < 1 || ACTUAL_WIDTH > 30) begin : g_param_check
      $error("otter_fetch_buffer: DEPTH must be a power of 2 >= 2 and ACTUAL_WIDTH in 1..30");
   end

   logic [31:0]   fetch_pc;
   logic [31:0]   pending_pc;
   logic          pending;
   logic [PW:0]   count;
   logic [PW:0]   occupancy;
   logic [PW:0]   count_after_pop;
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] head_nxt;
   logic [PW-1:0] tail_ptr;
   logic [31:0]   fifo_ir [DEPTH];
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   head_ir;
   logic [31:0]   head_pc;
   logic          issue;
   logic          push;
   logic          pop;

   // count + pending never exceeds DEPTH, so the issue rule alone prevents overflow
   assign occupancy       = count + (PW + 1)'(pending);
   assign issue           = !RST && !REDIRECT && (occupancy < DEPTH_C);
   assign push            = pending && !REDIRECT;
   assign pop             = IR_VALID && IR_READY && !REDIRECT;
   assign count_after_pop = count - (PW + 1)'(pop);
   assign head_nxt        = pop ? head_ptr + PW'(1) : head_ptr;

   assign MEM_ADDR1 = fetch_pc;
   assign MEM_READ1 = issue;
   assign IR_VALID  = (count != '0);
   assign IR        = head_ir;
   assign IR_PC     = head_pc;

`ifdef OTTER_FETCH_ERR_EN
   logic pending_err;
   logic head_err;
   logic fetch_err;
   logic fifo_err [DEPTH];

   assign fetch_err = ({32'd0, fetch_pc} >= (64'd1 << (ACTUAL_WIDTH + 2)));
   assign IR_ERR    = head_err;
`else
   assign IR_ERR    = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc   <= RESET_PC;
         pending    <= 1'b0;
         pending_pc <= '0;
         count      <= '0;
         head_ptr   <= '0;
         tail_ptr   <= '0;
         head_ir    <= '0;
         head_pc    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_ir[i] <= '0;
            fifo_pc[i] <= '0;
`ifdef OTTER_FETCH_ERR_EN
            fifo_err[i] <= 1'b0;
`endif
         end
`ifdef OTTER_FETCH_ERR_EN
         pending_err <= 1'b0;
         head_err    <= 1'b0;
`endif
      end else if (REDIRECT) begin
         // In-flight response and any pop this cycle are dropped with the flush
         fetch_pc <= REDIRECT_PC & ~32'h3;
         pending  <= 1'b0;
         count    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
      end else begin
         pending <= issue;
         if (issue) begin
            pending_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + 32'd4;
`ifdef OTTER_FETCH_ERR_EN
            pending_err <= fetch_err;
`endif
         end
         if (push) begin
            fifo_ir[tail_ptr] <= MEM_DOUT1;
            fifo_pc[tail_ptr] <= pending_pc;
            tail_ptr          <= tail_ptr + PW'(1);
`ifdef OTTER_FETCH_ERR_EN
            fifo_err[tail_ptr] <= pending_err;
`endif
         end
         head_ptr <= head_nxt;
         count    <= count_after_pop + (PW + 1)'(push);
         // Head registers only change when a new head exists, so they hold while empty
         if (count_after_pop == '0) begin
            if (push) begin
               head_ir <= MEM_DOUT1;
               head_pc <= pending_pc;
`ifdef OTTER_FETCH_ERR_EN
               head_err <= pending_err;
`endif
            end
         end else begin
            head_ir <= fifo_ir[head_nxt];
            head_pc <= fifo_pc[head_nxt];
`ifdef OTTER_FETCH_ERR_EN
            head_err <= fifo_err[head_nxt];
`endif
         end
      end
   end

endmodule

// File: doc/otter_fetch_buffer.md
Name: otter_fetch_buffer

Overview:
- Instruction fetch stage sitting directly upstream of the dual-port memory's instruction port (port 1).
- Owns the fetch PC and issues word reads on MEM_ADDR1/MEM_READ1, accounting for the memory's 1-cycle registered read latency.
- Captures returned words into a small FIFO tagged with their PC, and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ACTUAL_WIDTH, 14, log2 of memory words; used for range checking.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- REDIRECT  input  1  flush and restart fetch at REDIRECT_PC.
- REDIRECT_PC  input  32  new fetch address; bits [1:0] forced to 0.
- MEM_ADDR1  output  32  instruction read address = fetch PC register.
- MEM_READ1  output  1  read strobe; memory samples on the rising CLK edge.
- MEM_DOUT1  input  32  read data, valid the cycle after MEM_READ1; holds its value otherwise.
- IR_VALID  output  1  FIFO head valid.
- IR  output  32  head instruction.
- IR_PC  output  32  head instruction address.
- IR_READY  input  1  decode accepts the head this cycle.
- IR_ERR  output  1  head fetched out of range (see Optional Feature).

Behaviour:
- Reset, sampled on a CLK edge, aborts everything in progress. Afterwards:
  - fetch_pc = RESET_PC; count = 0; pending = 0.
  - All FIFO entries are 0; IR_VALID = 0; MEM_READ1 = 0; IR = 0; IR_PC = 0; IR_ERR = 0.
  - A response arriving in the first post-reset cycle is discarded.
- Issue:
  - MEM_READ1 = !RST && !REDIRECT && (count + pending < DEPTH). Combinational from registered state and REDIRECT only.
  - On issue: pending <= 1, pending_pc <= fetch_pc, fetch_pc <= fetch_pc + 4. The increment wraps modulo 2^32.
  - With no issue, pending <= 0.
- Capture:
  - When pending = 1 and REDIRECT = 0, write {MEM_DOUT1, pending_pc, err} at the tail.
  - Capacity is guaranteed by the issue rule, so no overflow check is needed.
- Latency: issue in cycle N → MEM_DOUT1 valid in N+1 → written at end of N+1 → IR_VALID in N+2.
- Throughput: sustained 1 instruction/cycle with IR_READY held high.
- Output:
  - IR_VALID = (count != 0).
  - IR, IR_PC and IR_ERR come from head registers.
  - Pop when IR_VALID && IR_READY && !REDIRECT.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect, in cycle R:
  - count <= 0, head/tail pointers <= 0, fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - No issue in cycle R.
  - The response arriving in R (from an issue in R-1) is discarded.
  - A pop requested in R is ignored.
  - First new issue occurs in R+1; IR_VALID rises no earlier than R+3.
- Redirect asserted on consecutive cycles: the last one wins. No instruction from an earlier target is ever delivered.
- Empty: IR_VALID = 0; IR/IR_PC hold the last head contents.
- Full (count + pending = DEPTH): MEM_READ1 = 0 until a pop occurs.
- Pointer wrap: modulo DEPTH using log2(DEPTH)-bit pointers; count is log2(DEPTH)+1 bits.
- Simultaneous RST and REDIRECT: RST wins.

Optional Feature:
- Macro: OTTER_FETCH_ERR_EN.
- Defined:
  - At issue, err = (fetch_pc >= 2**(ACTUAL_WIDTH+2)).
  - err travels with the entry; IR_ERR = head err bit.
  - Fetching continues normally; decode raises the trap.
- Undefined: err storage is omitted and IR_ERR is tied to 0.

Test Plan:
- Reset with RESET_PC = 0; memory words 0x00000013, 0x00100093, 0x00200113 at 0/4/8; IR_READY = 1; release RST at cycle 0.
  - MEM_READ1 = 1 from cycle 0 with MEM_ADDR1 = 0, 4, 8.
  - IR_VALID = 1 at cycle 2 with IR = 0x00000013, IR_PC = 0.
  - Consecutive IR_PC values 4 and 8 in cycles 3 and 4.
- IR_READY = 0 from reset: exactly 4 issues (addresses 0x0–0xC), then MEM_READ1 = 0. IR stays the word at 0, IR_VALID stays 1. One IR_READY pulse → exactly one further issue at 0x10.
- FIFO holding 3 entries plus one pending; REDIRECT = 1 with REDIRECT_PC = 0x100 and IR_READY = 1 in cycle R.
  - IR_VALID = 0 in R+1 and R+2.
  - MEM_ADDR1 = 0x100 with MEM_READ1 = 1 in R+1.
  - IR_PC = 0x100 in R+3; no old PC ever appears.
- REDIRECT_PC = 0x203 → fetched addresses 0x200, 0x204, ... Back-to-back REDIRECTs to 0x40 then 0x80 → first delivered IR_PC = 0x80.
- RST asserted for one cycle with 2 entries buffered and one pending → IR_VALID = 0 next cycle, MEM_ADDR1 = RESET_PC, stale response not delivered.
- With OTTER_FETCH_ERR_EN and ACTUAL_WIDTH = 14, REDIRECT_PC = 0x0000FFFC → IR_ERR = 0 at IR_PC 0xFFFC, IR_ERR = 1 at IR_PC 0x10000. Without the macro, IR_ERR = 0 throughout.
